// File: rtl/f2h_burst_arbiter_if.sv
// Byte-stream bundle between four requesters, the burst arbiter and the f2h FIFO producer port.
// Handshake: a byte moves on a rising clock edge exactly when its valid and ready are both high; valid never waits on ready.
interface f2h_burst_arbiter_if;
    logic [3:0]  reqValid_in;
    logic [15:0] reqLen_in;
    logic [31:0] reqData_in;
    logic [3:0]  reqReady_out;
    logic [7:0]  outData_out;
    logic        outValid_out;
    logic        outReady_in;

    modport master (
        input  reqValid_in, reqLen_in, reqData_in, outReady_in,
        output reqReady_out, outData_out, outValid_out
    );

    modport slave (
        output reqValid_in, reqLen_in, reqData_in, outReady_in,
        input  reqReady_out, outData_out, outValid_out
    );
endinterface

// File: rtl/f2h_burst_arbiter.sv
// Round-robin burst arbiter: four byte-stream requesters share one FIFO producer port,
// each grant emitting an optional {source, length} header followed by exactly that many bytes.
module f2h_burst_arbiter #(
    parameter bit HEADER_EN = 1'b1
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic                       enable_in,
    f2h_burst_arbiter_if.master        bus,
    output logic [3:0]                 grant_out,
    output logic                       busy_out,
    output logic [1:0]                 state_out
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t     state, stateNext;
    logic [1:0] grantIdx, lastIdx;
    logic [4:0] remaining, lenQ;
    logic [1:0] pickIdx, candIdx;
    logic       pickValid;
    logic [3:0] pickLenRaw;
    logic [4:0] pickLen;
    logic       headerXfer, dataXfer;
    logic [3:0] grantComb, reqReadyComb;
    logic [7:0] outDataComb;
    logic       outValidComb;

    // Search starts just after the last served requester, so it gets lowest priority.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = lastIdx;
        candIdx   = lastIdx;
        for (int k = 1; k <= 4; k++) begin
            candIdx = lastIdx + 2'(k);
            if (!pickValid && bus.reqValid_in[candIdx]) begin
                pickValid = 1'b1;
                pickIdx   = candIdx;
            end
        end
    end

    assign pickLenRaw = bus.reqLen_in[{pickIdx, 2'b00} +: 4];
    assign pickLen    = (pickLenRaw == 4'd0) ? 5'd16 : {1'b0, pickLenRaw};

    always_comb begin
        stateNext    = state;
        grantComb    = 4'b0000;
        reqReadyComb = 4'b0000;
        outDataComb  = 8'h00;
        outValidComb = 1'b0;
        headerXfer   = 1'b0;
        dataXfer     = 1'b0;
        case (state)
            IDLE: begin
                if (enable_in && pickValid) begin
                    if (HEADER_EN) stateNext = HEADER;
                    else           stateNext = DATA;
                end
            end
            HEADER: begin
                grantComb[grantIdx] = 1'b1;
                outValidComb        = 1'b1;
                outDataComb         = {grantIdx, 2'b00, lenQ[3:0]};
                if (bus.outReady_in) begin
                    headerXfer = 1'b1;
                    stateNext  = DATA;
                end
            end
            DATA: begin
                grantComb[grantIdx]    = 1'b1;
                outValidComb           = bus.reqValid_in[grantIdx];
                outDataComb            = bus.reqData_in[{grantIdx, 3'b000} +: 8];
                reqReadyComb[grantIdx] = bus.outReady_in;
                if (bus.reqValid_in[grantIdx] && bus.outReady_in) begin
                    dataXfer = 1'b1;
                    if (remaining == 5'd1) stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state <= IDLE;
        else           state <= stateNext;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            grantIdx  <= 2'd0;
            lastIdx   <= 2'd3;
            remaining <= 5'd0;
            lenQ      <= 5'd0;
        end else begin
            // Length is captured at grant time; later changes on reqLen_in are ignored.
            if (state == IDLE && stateNext != IDLE) begin
                grantIdx <= pickIdx;
                lenQ     <= pickLen;
                if (!HEADER_EN) remaining <= pickLen;
            end
            if (headerXfer) remaining <= lenQ;
            if (dataXfer) begin
                remaining <= remaining - 5'd1;
                if (remaining == 5'd1) lastIdx <= grantIdx;
            end
        end
    end

    assign grant_out        = grantComb;
    assign busy_out         = (state != IDLE);
    assign state_out        = state;
    assign bus.reqReady_out = reqReadyComb;
    assign bus.outData_out  = outDataComb;
    assign bus.outValid_out = outValidComb;
endmodule

// File: doc/f2h_burst_arbiter.md
Name: f2h_burst_arbiter

Overview:
- Round-robin arbiter that shares one FIFO producer port (8-bit data/valid/ready) among four byte-stream requesters.
- Typical sink: the read FIFO drained by comm_fpga channel 0.
- Each grant yields one burst: a header byte identifying source and length, then exactly that many data bytes from the granted requester. The host can demultiplex the sources from the single f2h stream.

Parameters:
- HEADER_EN, 1, 1 = emit header byte before each burst; 0 = data bytes only (still burst-granular arbitration).

Ports:
- clk_in  input  1  system clock (fx2Clk_in domain), rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  1 = new bursts may be granted; 0 = finish the current burst, then hold idle.
- reqValid_in  input  4  per requester: has data/wants grant.
- reqLen_in  input  16  per requester 4-bit burst length, [4i+3:4i]; 0 encodes 16, else 1..15. Requester holds it stable while reqValid_in[i]=1.
- reqData_in  input  32  per requester data byte, [8i+7:8i].
- reqReady_out  output  4  per-requester pop strobe: byte i consumed on this edge when reqReady_out[i] & reqValid_in[i].
- grant_out  output  4  one-hot current grant; 0 when idle.
- outData_out  output  8  to FIFO inputData_in.
- outValid_out  output  1  to FIFO inputValid_in.
- outReady_in  input  1  from FIFO inputReady_out.
- busy_out  output  1  1 while a burst (header or data) is in progress.

Behaviour:
- Reset state (async, reset_in=0): state IDLE; grant_out=0; reqReady_out=0; outValid_out=0; outData_out=0x00; busy_out=0; last-grant pointer=3, so requester 0 has first priority; remaining counter=0.
- States: IDLE, HEADER, DATA. Registered: state, grant index, last-grant pointer, 5-bit remaining counter, latched length.
- IDLE:
  - If enable_in=1 and any reqValid_in bit is set, grant the first set bit searching last+1, last+2, ... mod 4.
  - Latch len = (reqLen_in[g]==0) ? 16 : reqLen_in[g]; set grant_out.
  - Next state is HEADER (HEADER_EN=1) or DATA (HEADER_EN=0).
  - Grant decision is one clock after request; no output valid in IDLE.
- HEADER:
  - outValid_out=1; outData_out = {g[1:0], 2'b00, len[3:0]}, where len field 0 means 16.
  - On outValid_out & outReady_in: remaining<=len, go to DATA.
  - Header is held stable until accepted.
- DATA:
  - outData_out = reqData_in[g] (combinational mux); outValid_out = reqValid_in[g]; reqReady_out[g] = outReady_in; all other reqReady_out bits 0.
  - Transfer occurs when reqValid_in[g] & outReady_in; remaining decrements.
  - Transfer with remaining==1: go to IDLE, grant_out<=0, last<=g.
  - Requester dropping valid mid-burst stalls the burst; it is never abandoned or truncated.
  - FIFO full (outReady_in=0) stalls with no pop and no decrement.
- With HEADER_EN=0, DATA is entered with remaining=len directly from IDLE.
- enable_in deasserted mid-burst has no effect until the burst completes. Requests in IDLE are ignored while enable_in=0.
- The requester just served has lowest priority at the next arbitration. Back-to-back bursts have exactly one IDLE cycle between them.
- Changes to reqLen_in after grant are ignored (latched).
- busy_out = (state != IDLE).
- Async reset mid-burst returns to the reset state immediately. The partial burst is lost; the host must resynchronise on header.

Test Plan:
- Reset: hold reset_in=0 with all reqValid_in=1 -> grant_out=0, outValid_out=0, reqReady_out=0; first grant after release goes to req0.
- Single burst: req2 valid, len=3, data 0xA0,0xA1,0xA2, outReady_in=1 -> stream 0x83,0xA0,0xA1,0xA2; 3 pops of req2; busy_out high 4 cycles plus 1 grant cycle; grant_out returns to 0.
- Round robin: all four requesting, len=1 each -> header order 0x01,0x41,0x81,0xC1, then 0x01 again; no requester starves.
- Len 0: req1 len=0 -> header 0x40, exactly 16 data bytes, then IDLE.
- Backpressure and stall: outReady_in low for 5 cycles during header and data, req valid toggling -> no byte duplicated, lost or reordered; remaining decrements only on transfer.
- HEADER_EN=0 and enable_in: with no header, bytes only; enable_in dropped mid-burst -> burst completes, no new grant until re-enabled; reset asserted mid-burst -> immediate idle.
